if_pc_stage: RTL and testbench

Fetch-stage sequencer for the pipelined CPU: owns the program counter and the IF/ID pipeline register. Drives the current PC to the instruction memory and to the PC+4 adder. Captures the adder's sum together with the fetched instruction into IF/ID. Applies hazard-unit stall, flush and branch-redirect requests with a fixed priority, and keeps a saturating stall counter for performance reporting.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pipe_reg.sv | 26 ++
 rtl/if_pc_stage.sv | 89 ++++++++
 tb/tb_if_pc_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage mode decode.
package cpu_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    MODE_ADVANCE  = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_FLUSH    = 2'd2,
    MODE_REDIRECT = 2'd3
  } fetch_mode_e;

  // Fixed priority: redirect beats flush beats stall beats advance.
  function automatic fetch_mode_e decode_mode(input logic branch, input logic flush,
                                              input logic stall);
    if (branch)     return MODE_REDIRECT;
    else if (flush) return MODE_FLUSH;
    else if (stall) return MODE_STALL;
    else            return MODE_ADVANCE;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: sync active-low reset, clear-to-constant, load enable.
module pipe_reg #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;

  // Reset wins, then clear, then load; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i)     r_q <= RST_VAL;
    else if (clr_i) r_q <= CLR_VAL;
    else if (en_i)  r_q <= d_i;
  end

  assign q_o = r_q;

endmodule

// File: rtl/if_pc_stage.sv
// Fetch stage: program counter, IF/ID register and saturating stall counter.
module if_pc_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        WIDTH     = cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0]   RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [WIDTH-1:0]   NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic [WIDTH-1:0] pc_plus4_i,
  input  logic [WIDTH-1:0] instr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] ifid_pc_plus4_o,
  output logic [WIDTH-1:0] ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  fetch_mode_e      w_mode;
  logic             w_pc_en;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_ifid_en;
  logic             w_ifid_clr;
  logic [CNT_W-1:0] r_stall_cnt;

  // Mode decode and register controls. A flush still lets the PC move
  // unless a stall is also present; a redirect ignores both.
  always_comb begin
    w_mode     = decode_mode(branch_taken_i, flush_i, stall_i);
    w_pc_en    = 1'b0;
    w_pc_next  = pc_plus4_i;
    w_ifid_en  = 1'b0;
    w_ifid_clr = 1'b0;
    unique case (w_mode)
      MODE_REDIRECT: begin
        w_pc_en    = 1'b1;
        w_pc_next  = branch_target_i;
        w_ifid_clr = 1'b1;
      end
      MODE_FLUSH: begin
        w_pc_en    = !stall_i;
        w_ifid_clr = 1'b1;
      end
      MODE_STALL: ;
      MODE_ADVANCE: begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
      end
      default: ;
    endcase
  end

  pipe_reg #(.W(WIDTH), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
    .clk_i (clk_i), .rst_i (rst_i), .en_i (w_pc_en), .clr_i (1'b0),
    .d_i   (w_pc_next), .q_o (pc_o)
  );

  pipe_reg #(.W(WIDTH), .RST_VAL('0), .CLR_VAL('0)) u_ifid_pc4 (
    .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ifid_en), .clr_i (w_ifid_clr),
    .d_i   (pc_plus4_i), .q_o (ifid_pc_plus4_o)
  );

  pipe_reg #(.W(WIDTH), .RST_VAL(NOP_INSTR), .CLR_VAL(NOP_INSTR)) u_ifid_instr (
    .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ifid_en), .clr_i (w_ifid_clr),
    .d_i   (instr_i), .q_o (ifid_instr_o)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_ifid_valid (
    .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ifid_en), .clr_i (w_ifid_clr),
    .d_i   (1'b1), .q_o (ifid_valid_o)
  );

  // Count stalled cycles not overridden by a redirect; saturate at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_stall_cnt <= '0;
    else if (stall_i && !branch_taken_i && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed self-checking bench for if_pc_stage (default and 4-bit counter builds).
module tb_if_pc_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch;
  logic [31:0] target;

  logic [31:0] pc_a, pc4_in_a, instr_in_a, ifid_pc4_a, ifid_instr_a;
  logic        valid_a;
  logic [15:0] cnt_a;

  logic [31:0] pc_b, pc4_in_b, instr_in_b, ifid_pc4_b, ifid_instr_b;
  logic        valid_b;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External adder and instruction memory models.
  assign pc4_in_a   = pc_a + 32'd4;
  assign instr_in_a = pc_a ^ 32'hA5A5_0000;
  assign pc4_in_b   = pc_b + 32'd4;
  assign instr_in_b = pc_b ^ 32'hA5A5_0000;

  if_pc_stage dut (
    .clk_i (clk), .rst_i (rst), .stall_i (stall), .flush_i (flush),
    .branch_taken_i (branch), .branch_target_i (target),
    .pc_plus4_i (pc4_in_a), .instr_i (instr_in_a),
    .pc_o (pc_a), .ifid_pc_plus4_o (ifid_pc4_a), .ifid_instr_o (ifid_instr_a),
    .ifid_valid_o (valid_a), .stall_cnt_o (cnt_a)
  );

  if_pc_stage #(.CNT_W(4)) dut4 (
    .clk_i (clk), .rst_i (rst), .stall_i (stall), .flush_i (flush),
    .branch_taken_i (branch), .branch_target_i (target),
    .pc_plus4_i (pc4_in_b), .instr_i (instr_in_b),
    .pc_o (pc_b), .ifid_pc_plus4_o (ifid_pc4_b), .ifid_instr_o (ifid_instr_b),
    .ifid_valid_o (valid_b), .stall_cnt_o (cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic f, input logic b, input logic [31:0] t);
    stall = s; flush = f; branch = b; target = t;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 32'h0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1, 1, 1, 32'h0000_0080);
    tick(); tick();
    n_checks++; if (pc_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_a, 32'h0); end
    n_checks++; if (ifid_pc4_a !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc4 got %h exp %h", ifid_pc4_a, 32'h0); end
    n_checks++; if (ifid_instr_a !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_instr got %h exp %h", ifid_instr_a, 32'h0); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
    n_checks++; if (cnt_b !== 4'd0) begin n_fail++; $display("FAIL reset_cnt4 got %0d exp 0", cnt_b); end
  endtask

  task automatic test_free_run();
    rst = 1'b1;
    set_in(0, 0, 0, 32'h0);
    tick(); tick(); tick();
    n_checks++; if (pc_a !== 32'hC) begin n_fail++; $display("FAIL run_pc got %h exp %h", pc_a, 32'hC); end
    n_checks++; if (ifid_pc4_a !== 32'hC) begin n_fail++; $display("FAIL run_ifid_pc4 got %h exp %h", ifid_pc4_a, 32'hC); end
    n_checks++; if (ifid_instr_a !== 32'hA5A5_0008) begin n_fail++; $display("FAIL run_ifid_instr got %h exp %h", ifid_instr_a, 32'hA5A5_0008); end
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL run_valid got %b exp 1", valid_a); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    for (int i = 1; i <= 2; i++) begin
      set_in(1, 0, 0, 32'h0);
      tick();
      n_checks++; if (pc_a !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp %h", i, pc_a, 32'h8); end
      n_checks++; if (ifid_pc4_a !== 32'h8 || ifid_instr_a !== 32'hA5A5_0004 || valid_a !== 1'b1)
        begin n_fail++; $display("FAIL stall_ifid[%0d] got %h/%h/%b exp 00000008/a5a50004/1", i, ifid_pc4_a, ifid_instr_a, valid_a); end
      n_checks++; if (cnt_a !== 16'(i)) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, cnt_a, i); end
    end
    set_in(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'hC || ifid_pc4_a !== 32'hC || ifid_instr_a !== 32'hA5A5_0008)
      begin n_fail++; $display("FAIL stall_resume got %h/%h/%h exp 0000000c/0000000c/a5a50008", pc_a, ifid_pc4_a, ifid_instr_a); end
    n_checks++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL stall_resume_cnt got %0d exp 2", cnt_a); end
  endtask

  task automatic test_redirect();
    set_in(1, 1, 1, 32'h0000_0040);
    tick();
    n_checks++; if (pc_a !== 32'h40) begin n_fail++; $display("FAIL redir_pc got %h exp %h", pc_a, 32'h40); end
    n_checks++; if (valid_a !== 1'b0 || ifid_instr_a !== 32'h0 || ifid_pc4_a !== 32'h0)
      begin n_fail++; $display("FAIL redir_bubble got %b/%h/%h exp 0/00000000/00000000", valid_a, ifid_instr_a, ifid_pc4_a); end
    n_checks++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL redir_cnt got %0d exp 2", cnt_a); end
    set_in(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h44 || ifid_instr_a !== 32'hA5A5_0040 || valid_a !== 1'b1)
      begin n_fail++; $display("FAIL redir_target_fetch got %h/%h/%b exp 00000044/a5a50040/1", pc_a, ifid_instr_a, valid_a); end
  endtask

  task automatic test_back_to_back();
    set_in(0, 0, 1, 32'h0000_0100);
    tick();
    set_in(0, 0, 1, 32'h0000_0203);
    tick();
    n_checks++; if (pc_a !== 32'h203 || valid_a !== 1'b0)
      begin n_fail++; $display("FAIL b2b_pc got %h/%b exp 00000203/0", pc_a, valid_a); end
    set_in(0, 0, 1, 32'hFFFF_FFFC);
    tick();
    set_in(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h0 || ifid_pc4_a !== 32'h0 || ifid_instr_a !== 32'h5A5A_FFFC || valid_a !== 1'b1)
      begin n_fail++; $display("FAIL wrap got %h/%h/%h/%b exp 00000000/00000000/5a5afffc/1", pc_a, ifid_pc4_a, ifid_instr_a, valid_a); end
  endtask

  task automatic test_flush();
    do_reset();
    tick(); tick(); tick(); tick();
    n_checks++; if (pc_a !== 32'h10) begin n_fail++; $display("FAIL flush_pre_pc got %h exp %h", pc_a, 32'h10); end
    set_in(1, 1, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h10 || valid_a !== 1'b0 || ifid_instr_a !== 32'h0 || ifid_pc4_a !== 32'h0)
      begin n_fail++; $display("FAIL flush_stall got %h/%b/%h/%h exp 00000010/0/00000000/00000000", pc_a, valid_a, ifid_instr_a, ifid_pc4_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL flush_stall_cnt got %0d exp 1", cnt_a); end
    set_in(0, 1, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h14 || valid_a !== 1'b0 || ifid_instr_a !== 32'h0)
      begin n_fail++; $display("FAIL flush_only got %h/%b/%h exp 00000014/0/00000000", pc_a, valid_a, ifid_instr_a); end
    set_in(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h18 || ifid_pc4_a !== 32'h18 || ifid_instr_a !== 32'hA5A5_0014 || valid_a !== 1'b1)
      begin n_fail++; $display("FAIL flush_resume got %h/%h/%h/%b exp 00000018/00000018/a5a50014/1", pc_a, ifid_pc4_a, ifid_instr_a, valid_a); end
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(1, 0, 0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15 || i == 20) begin
        n_checks++; if (cnt_b !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4[%0d] got %0d exp 15", i, cnt_b); end
      end
    end
    n_checks++; if (cnt_a !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16 got %0d exp 20", cnt_a); end
    n_checks++; if (pc_b !== 32'h0 || valid_b !== 1'b0) begin n_fail++; $display("FAIL sat_hold got %h/%b exp 00000000/0", pc_b, valid_b); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_in(0, 0, 0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    set_in(1, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h24 || cnt_a !== 16'd1) begin n_fail++; $display("FAIL mid_pre got %h/%0d exp 00000024/1", pc_a, cnt_a); end
    rst = 1'b0;
    set_in(1, 1, 1, 32'h0000_0080);
    tick();
    n_checks++; if (pc_a !== 32'h0 || ifid_pc4_a !== 32'h0 || ifid_instr_a !== 32'h0 || valid_a !== 1'b0 || cnt_a !== 16'd0)
      begin n_fail++; $display("FAIL mid_reset got %h/%h/%h/%b/%0d exp all zero", pc_a, ifid_pc4_a, ifid_instr_a, valid_a, cnt_a); end
    rst = 1'b1;
    set_in(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_a !== 32'h4 || ifid_pc4_a !== 32'h4 || ifid_instr_a !== 32'hA5A5_0000 || valid_a !== 1'b1)
      begin n_fail++; $display("FAIL mid_release got %h/%h/%h/%b exp 00000004/00000004/a5a50000/1", pc_a, ifid_pc4_a, ifid_instr_a, valid_a); end
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 32'h0);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
